// File: rtl/inv_key_schedule.sv
// inv_key_schedule: AES-128 key expansion run forward, then round keys emitted 10 down to 0 under ready/valid.
// Define INV_MIXCOL_KEY_EN to emit InvMixColumns(round key) for rounds 1..9 (equivalent inverse cipher).
module inv_key_schedule #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         rk_last
);
  typedef enum logic [1:0] {IDLE, FWD, EMIT} state_t;
  localparam logic [7:0] RCON [0:15] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                         8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // S-box as GF(2^8) inverse (x^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, inv;
    sq = x;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction
`ifdef INV_MIXCOL_KEY_EN
  function automatic logic [127:0] inv_mix(input logic [127:0] k);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = k[127-32*c -: 32];
      o[127-32*c -: 32] = {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                           gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                           gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                           gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    end
    return o;
  endfunction
`endif
  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [127:0]  key_q, key_d;
  logic [31:0]   w0, w1, w2, w3, p3, sw_in, sw_out, t, f0, f1, f2, f3;
  logic [7:0]    rcon;
  assign {w0, w1, w2, w3} = key_q;
  assign p3 = w3 ^ w2;
  // One shared SubWord: forward step uses w3, backward step uses w3^w2; RotWord is folded into the byte order
  assign sw_in  = (state_q == EMIT) ? p3 : w3;
  assign sw_out = {sbox(sw_in[23:16]), sbox(sw_in[15:8]), sbox(sw_in[7:0]), sbox(sw_in[31:24])};
  assign rcon   = RCON[(state_q == EMIT) ? cnt_q : cnt_q + 4'd1];
  assign t  = sw_out ^ {rcon, 24'h0};
  assign f0 = w0 ^ t;
  assign f1 = w1 ^ f0;
  assign f2 = w2 ^ f1;
  assign f3 = w3 ^ f2;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    unique case (state_q)
      IDLE: if (start) begin
        key_d   = key_in;
        cnt_d   = '0;
        state_d = FWD;
      end
      FWD: begin
        key_d   = {f0, f1, f2, f3};
        cnt_d   = cnt_q + 4'd1;
        state_d = (cnt_q == 4'(NR - 1)) ? EMIT : FWD;
      end
      EMIT: if (rk_ready) begin
        state_d = (cnt_q == 4'd0) ? IDLE : EMIT;
        key_d   = (cnt_q == 4'd0) ? key_q : {f0, w1 ^ w0, w2 ^ w1, p3};
        cnt_d   = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
    end
  end
  assign busy     = state_q != IDLE;
  assign rk_valid = state_q == EMIT;
  assign rk_round = cnt_q;
  assign rk_last  = rk_valid && cnt_q == 4'd0;
`ifdef INV_MIXCOL_KEY_EN
  assign rk_out = (rk_valid && cnt_q != 4'd0 && cnt_q != 4'(NR)) ? inv_mix(key_q) : key_q;
`else
  assign rk_out = key_q;
`endif
endmodule

// File: tb/tb_inv_key_schedule.sv
// tb_inv_key_schedule: directed checks of the inverse key schedule against FIPS-197 AES-128 round keys.
module tb_inv_key_schedule;
  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, rk_ready = 1'b0;
  logic [127:0] key_in = '0;
  logic         busy, rk_valid, rk_last;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  int n_chk = 0, n_pass = 0;
  localparam logic [127:0] EK [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
  inv_key_schedule #(.NR(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .busy(busy), .rk_valid(rk_valid),
    .rk_ready(rk_ready), .rk_out(rk_out), .rk_round(rk_round), .rk_last(rk_last));
  always #5 clk = ~clk;
`ifdef INV_MIXCOL_KEY_EN
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [127:0] imc(input logic [127:0] k);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = k[127-32*c -: 32];
      o[127-32*c -: 32] = {gm(a0, 14) ^ gm(a1, 11) ^ gm(a2, 13) ^ gm(a3, 9),
                           gm(a0, 9) ^ gm(a1, 14) ^ gm(a2, 11) ^ gm(a3, 13),
                           gm(a0, 13) ^ gm(a1, 9) ^ gm(a2, 14) ^ gm(a3, 11),
                           gm(a0, 11) ^ gm(a1, 13) ^ gm(a2, 9) ^ gm(a3, 14)};
    end
    return o;
  endfunction
  function automatic logic [127:0] exp_key(input int r);
    return (r > 0 && r < 10) ? imc(EK[r]) : EK[r];
  endfunction
`else
  function automatic logic [127:0] exp_key(input int r);
    return EK[r];
  endfunction
`endif
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got %h exp %h", tag, got, exp);
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 128'(busy), 128'd0);
    chk({tag, "_valid"}, 128'(rk_valid), 128'd0);
    chk({tag, "_out"}, rk_out, 128'd0);
    chk({tag, "_round"}, 128'(rk_round), 128'd0);
    chk({tag, "_last"}, 128'(rk_last), 128'd0);
  endtask
  task automatic launch(input logic [127:0] k, input bit keep);
    start  = 1'b1;
    key_in = k;
    step;
    start  = keep;
    key_in = 128'h00112233445566778899aabbccddeeff;
  endtask
  task automatic wait_valid;
    int n = 0;
    while (!rk_valid && n < 30) begin
      step;
      n++;
    end
    chk("latency", 128'(n), 128'd10);
  endtask
  task automatic consume(input int lo, input int max_stall);
    for (int r = 10; r >= lo; r--) begin
      rk_ready = 1'b0;
      repeat ($urandom_range(max_stall)) begin
        chk("stall_out", rk_out, exp_key(r));
        chk("stall_round", 128'(rk_round), 128'(r));
        chk("stall_valid", 128'(rk_valid), 128'd1);
        step;
      end
      rk_ready = 1'b1;
      chk("key", rk_out, exp_key(r));
      chk("round", 128'(rk_round), 128'(r));
      chk("valid", 128'(rk_valid), 128'd1);
      chk("last", 128'(rk_last), 128'(r == 0));
      step;
      rk_ready = 1'b0;
    end
  endtask
  initial begin
    #100000;
    $error("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end
  initial begin
    start  = 1'b1;
    key_in = EK[0];
    step;
    step;
    chk_idle("reset");
    rst_n = 1'b1;
    start = 1'b0;
    step;
    chk("start_in_reset", 128'(busy), 128'd0);
    launch(EK[0], 1'b0);
    chk("busy_fwd", 128'(busy), 128'd1);
    chk("valid_fwd", 128'(rk_valid), 128'd0);
    wait_valid;
    consume(0, 0);
    chk("done_busy", 128'(busy), 128'd0);
    chk("done_valid", 128'(rk_valid), 128'd0);
    launch(EK[0], 1'b1);
    wait_valid;
    consume(0, 3);
    chk("start_at_last", 128'(busy), 128'd0);
    start = 1'b0;
    step;
    chk("idle_after", 128'(busy), 128'd0);
    launch(EK[0], 1'b0);
    wait_valid;
    consume(6, 1);
    chk("mid_round", 128'(rk_round), 128'd5);
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    chk_idle("mid_reset");
    launch(EK[0], 1'b0);
    wait_valid;
    consume(0, 0);
    chk("final_busy", 128'(busy), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
